// File: rtl/ph1_cfg_pkg.sv
// Shared types and bank geometry for the Phase 1 coefficient loader.
package ph1_cfg_pkg;

  typedef enum logic [2:0] {
    BANK_FRAC_DEC = 3'd0,
    BANK_NUM_2_4  = 3'd1,
    BANK_DEN_2_4  = 3'd2,
    BANK_NUM_2    = 3'd3,
    BANK_DEN_2    = 3'd4,
    BANK_NUM_1    = 3'd5,
    BANK_DEN_1    = 3'd6,
    BANK_ILLEGAL  = 3'd7
  } cfg_bank_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ERROR  = 3'd4
  } loader_state_e;

  localparam logic [6:0] FRAC_DEC_DEPTH  = 7'd72;
  localparam logic [6:0] NUM_COEFF_DEPTH = 7'd3;
  localparam logic [6:0] DEN_COEFF_DEPTH = 7'd2;

  // The illegal bank reports depth 0 so every index on it is out of range.
  function automatic logic [6:0] bank_depth(input cfg_bank_e bank);
    case (bank)
      BANK_FRAC_DEC:                     return FRAC_DEC_DEPTH;
      BANK_NUM_2_4, BANK_NUM_2, BANK_NUM_1: return NUM_COEFF_DEPTH;
      BANK_DEN_2_4, BANK_DEN_2, BANK_DEN_1: return DEN_COEFF_DEPTH;
      default:                           return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ph1_cfg_bank_reg.sv
// One committed coefficient bank: array loaded on commit plus a one-cycle wr_en pulse.
module ph1_cfg_bank_reg #(
  parameter int DEPTH       = 3,
  parameter int COEFF_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [DEPTH*COEFF_WIDTH-1:0] load_data,
  output logic                         wr_en,
  output logic [DEPTH*COEFF_WIDTH-1:0] data_out
);

  logic                         wr_en_reg;
  logic [DEPTH*COEFF_WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      wr_en_reg <= load;
      if (load) data_reg <= load_data;
    end
  end

  assign wr_en    = wr_en_reg;
  assign data_out = data_reg;

endmodule

// File: rtl/ph1_coeff_loader.sv
// Burst-oriented coefficient loader: validates each burst in a shadow buffer
// and commits it to exactly one Phase 1 coefficient bank.
module ph1_coeff_loader
  import ph1_cfg_pkg::*;
#(
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [2:0]                         cfg_bank,
  input  logic [6:0]                         cfg_index,
  input  logic [COEFF_WIDTH-1:0]             cfg_data,
  input  logic                               cfg_last,
  output logic                               cfg_error,
  output logic                               frac_dec_coeff_wr_en,
  output logic [COEFF_WIDTH*N_TAP-1:0]       frac_dec_coeff_data_out,
  output logic                               iir_num_coeff_2_4_wr_en,
  output logic                               iir_den_coeff_2_4_wr_en,
  output logic                               iir_num_coeff_2_wr_en,
  output logic                               iir_den_coeff_2_wr_en,
  output logic                               iir_num_coeff_1_wr_en,
  output logic                               iir_den_coeff_1_wr_en,
  output logic [COEFF_WIDTH*3-1:0]           iir_num_coeff_2_4_out,
  output logic [COEFF_WIDTH*3-1:0]           iir_num_coeff_2_out,
  output logic [COEFF_WIDTH*3-1:0]           iir_num_coeff_1_out,
  output logic [COEFF_WIDTH*2-1:0]           iir_den_coeff_2_4_out,
  output logic [COEFF_WIDTH*2-1:0]           iir_den_coeff_2_out,
  output logic [COEFF_WIDTH*2-1:0]           iir_den_coeff_1_out
);

  loader_state_e state_reg, state_next;
  logic [6:0]    count_reg, count_next;
  logic [2:0]    bank_reg, bank_next;
  logic          ready_reg, ready_next;
  logic          error_reg, error_next;
  logic          commit;
  logic          shadow_we;

  logic [COEFF_WIDTH-1:0]       shadow_mem [N_TAP];
  logic [COEFF_WIDTH*N_TAP-1:0] commit_flat;
  logic [6:0]                   load_sel;

  logic       hs;
  logic [6:0] depth;
  logic       idx_ok, last_ok, word_good;

  assign hs      = cfg_valid && ready_reg;
  assign depth   = bank_depth(cfg_bank_e'(cfg_bank));
  assign idx_ok  = (cfg_index == count_reg) && (cfg_index < depth);
  assign last_ok = (cfg_last == (cfg_index == depth - 7'd1));

  // First word only needs a legal bank; later words must stay on the latched one.
  always_comb begin
    word_good = idx_ok && last_ok;
    if (state_reg == ST_IDLE) word_good = word_good && (cfg_bank != BANK_ILLEGAL);
    else                      word_good = word_good && (cfg_bank == bank_reg);
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    bank_next  = bank_reg;
    error_next = 1'b0;
    commit     = 1'b0;
    shadow_we  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_LOAD: begin
        if (hs) begin
          count_next = count_reg + 7'd1;
          if (state_reg == ST_IDLE) bank_next = cfg_bank;
          if (word_good) begin
            shadow_we = 1'b1;
            if (cfg_last) begin
              commit     = 1'b1;
              state_next = ST_COMMIT;
            end else begin
              state_next = ST_LOAD;
            end
          end else if (cfg_last) begin
            error_next = 1'b1;
            state_next = ST_ERROR;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (hs && cfg_last) begin
          error_next = 1'b1;
          state_next = ST_ERROR;
        end
      end
      default: begin
        count_next = 7'd0;
        state_next = ST_IDLE;
      end
    endcase
    ready_next = (state_next == ST_IDLE) || (state_next == ST_LOAD) ||
                 (state_next == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= 7'd0;
      bank_reg  <= 3'd0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      bank_reg  <= bank_next;
      ready_reg <= ready_next;
      error_reg <= error_next;
    end
  end

  // Stale shadow contents never escape: a good burst rewrites every index before commit.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_mem[cfg_index] <= cfg_data;
  end

  // The final word is merged here so it lands in the bank on the same edge.
  generate
    for (genvar gi = 0; gi < N_TAP; gi++) begin : g_commit
      assign commit_flat[gi*COEFF_WIDTH +: COEFF_WIDTH] =
        (cfg_index == 7'(gi)) ? cfg_data : shadow_mem[gi];
    end
    for (genvar gi = 0; gi < 7; gi++) begin : g_sel
      assign load_sel[gi] = commit && (bank_next == 3'(gi));
    end
  endgenerate

  assign cfg_ready = ready_reg;
  assign cfg_error = error_reg;

  ph1_cfg_bank_reg #(.DEPTH(N_TAP), .COEFF_WIDTH(COEFF_WIDTH)) u_frac_dec (
    .clk(clk), .rst(rst), .load(load_sel[0]), .load_data(commit_flat),
    .wr_en(frac_dec_coeff_wr_en), .data_out(frac_dec_coeff_data_out));

  ph1_cfg_bank_reg #(.DEPTH(3), .COEFF_WIDTH(COEFF_WIDTH)) u_num_2_4 (
    .clk(clk), .rst(rst), .load(load_sel[1]), .load_data(commit_flat[COEFF_WIDTH*3-1:0]),
    .wr_en(iir_num_coeff_2_4_wr_en), .data_out(iir_num_coeff_2_4_out));

  ph1_cfg_bank_reg #(.DEPTH(2), .COEFF_WIDTH(COEFF_WIDTH)) u_den_2_4 (
    .clk(clk), .rst(rst), .load(load_sel[2]), .load_data(commit_flat[COEFF_WIDTH*2-1:0]),
    .wr_en(iir_den_coeff_2_4_wr_en), .data_out(iir_den_coeff_2_4_out));

  ph1_cfg_bank_reg #(.DEPTH(3), .COEFF_WIDTH(COEFF_WIDTH)) u_num_2 (
    .clk(clk), .rst(rst), .load(load_sel[3]), .load_data(commit_flat[COEFF_WIDTH*3-1:0]),
    .wr_en(iir_num_coeff_2_wr_en), .data_out(iir_num_coeff_2_out));

  ph1_cfg_bank_reg #(.DEPTH(2), .COEFF_WIDTH(COEFF_WIDTH)) u_den_2 (
    .clk(clk), .rst(rst), .load(load_sel[4]), .load_data(commit_flat[COEFF_WIDTH*2-1:0]),
    .wr_en(iir_den_coeff_2_wr_en), .data_out(iir_den_coeff_2_out));

  ph1_cfg_bank_reg #(.DEPTH(3), .COEFF_WIDTH(COEFF_WIDTH)) u_num_1 (
    .clk(clk), .rst(rst), .load(load_sel[5]), .load_data(commit_flat[COEFF_WIDTH*3-1:0]),
    .wr_en(iir_num_coeff_1_wr_en), .data_out(iir_num_coeff_1_out));

  ph1_cfg_bank_reg #(.DEPTH(2), .COEFF_WIDTH(COEFF_WIDTH)) u_den_1 (
    .clk(clk), .rst(rst), .load(load_sel[6]), .load_data(commit_flat[COEFF_WIDTH*2-1:0]),
    .wr_en(iir_den_coeff_1_wr_en), .data_out(iir_den_coeff_1_out));

endmodule

// File: tb/tb_ph1_coeff_loader.sv
// Self-checking bench: burst-level reference model, vector table, corner sequences, random bursts.
module tb_ph1_coeff_loader;
  localparam int W  = 20;
  localparam int NT = 72;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [2:0] cfg_bank = '0;
  logic [6:0] cfg_index = '0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_last = 1'b0;
  logic cfg_ready, cfg_error;
  logic frac_wr, n24_wr, d24_wr, n2_wr, d2_wr, n1_wr, d1_wr;
  logic [W*NT-1:0] frac_out;
  logic [W*3-1:0] n24_out, n2_out, n1_out;
  logic [W*2-1:0] d24_out, d2_out, d1_out;
  logic [6:0] dut_wr;

  ph1_coeff_loader #(.COEFF_WIDTH(W), .N_TAP(NT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bank(cfg_bank), .cfg_index(cfg_index), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_error(cfg_error),
    .frac_dec_coeff_wr_en(frac_wr), .frac_dec_coeff_data_out(frac_out),
    .iir_num_coeff_2_4_wr_en(n24_wr), .iir_den_coeff_2_4_wr_en(d24_wr),
    .iir_num_coeff_2_wr_en(n2_wr), .iir_den_coeff_2_wr_en(d2_wr),
    .iir_num_coeff_1_wr_en(n1_wr), .iir_den_coeff_1_wr_en(d1_wr),
    .iir_num_coeff_2_4_out(n24_out), .iir_num_coeff_2_out(n2_out), .iir_num_coeff_1_out(n1_out),
    .iir_den_coeff_2_4_out(d24_out), .iir_den_coeff_2_out(d2_out), .iir_den_coeff_1_out(d1_out));

  assign dut_wr = {d1_wr, n1_wr, d2_wr, n2_wr, d24_wr, n24_wr, frac_wr};

  always #5 clk = ~clk;

  // Reference model state: expected committed banks and expected outputs this cycle.
  logic [W-1:0] m_coef [7][NT];
  logic         m_ready, m_err;
  logic [6:0]   m_wr;
  int           q_bank[$], q_idx[$];
  logic [W-1:0] q_data[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int frac_pulses = 0, wr2_cyc = -1, wr5_cyc = -1;

  int s_b[$], s_i[$];
  logic [W-1:0] s_d[$];
  logic s_l[$];

  function automatic int ref_depth(input int b);
    if (b == 0) return 72;
    if (b == 7) return 0;
    return (b % 2 == 1) ? 3 : 2;
  endfunction

  function automatic logic [W-1:0] dut_word(input int b, input int k);
    case (b)
      0: return frac_out[k*W +: W];
      1: return n24_out[k*W +: W];
      2: return d24_out[k*W +: W];
      3: return n2_out[k*W +: W];
      4: return d2_out[k*W +: W];
      5: return n1_out[k*W +: W];
      default: return d1_out[k*W +: W];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // A burst is good iff it is on a legal bank, has exactly D words, stays on
  // one bank and carries indices 0,1,..,D-1 in order.
  task automatic model_burst_end();
    int  b0;
    bit  ok;
    b0 = q_bank[0];
    ok = (b0 != 7) && (q_bank.size() == ref_depth(b0));
    for (int k = 0; k < q_bank.size(); k++)
      if (q_bank[k] != b0 || q_idx[k] != k) ok = 0;
    if (ok) begin
      m_wr[b0] = 1'b1;
      for (int k = 0; k < q_bank.size(); k++) m_coef[b0][k] = q_data[k];
    end else begin
      m_err = 1'b1;
    end
    q_bank.delete(); q_idx.delete(); q_data.delete();
  endtask

  task automatic compare_all();
    int bad;
    chk("ready", 32'(cfg_ready), 32'(m_ready));
    chk("error", 32'(cfg_error), 32'(m_err));
    chk("wr_en", 32'(dut_wr), 32'(m_wr));
    bad = 0;
    for (int b = 0; b < 7; b++)
      for (int k = 0; k < ref_depth(b); k++)
        if (dut_word(b, k) !== m_coef[b][k]) begin
          if (bad == 0) $display("FAIL data cyc=%0d bank=%0d tap=%0d: got %0h expected %0h",
                                 cyc, b, k, dut_word(b, k), m_coef[b][k]);
          bad++;
        end
    n_tests++;
    if (bad != 0) n_fail++;
    if (dut_wr[0]) frac_pulses++;
    if (dut_wr[2]) wr2_cyc = cyc;
    if (dut_wr[5]) wr5_cyc = cyc;
  endtask

  task automatic tick(input logic v, input logic [2:0] b, input logic [6:0] i,
                      input logic [W-1:0] d, input logic l, input logic r, output logic hs);
    cfg_valid = v; cfg_bank = b; cfg_index = i; cfg_data = d; cfg_last = l; rst = r;
    @(posedge clk);
    hs = v && m_ready && !r;
    m_wr = '0;
    m_err = 1'b0;
    if (r) begin
      m_ready = 1'b0;
      q_bank.delete(); q_idx.delete(); q_data.delete();
      for (int bb = 0; bb < 7; bb++) for (int k = 0; k < NT; k++) m_coef[bb][k] = '0;
    end else begin
      if (hs) begin
        q_bank.push_back(int'(b)); q_idx.push_back(int'(i)); q_data.push_back(d);
        if (l) model_burst_end();
      end
      m_ready = !(hs && l);
    end
    cyc++;
    @(negedge clk);
    $display("[TB] cyc=%0d v=%0b bank=%0d idx=%0d data=%0h last=%0b rst=%0b -> ready=%0b err=%0b wr=%07b",
             cyc, v, b, i, d, l, r, cfg_ready, cfg_error, dut_wr);
    compare_all();
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int k = 0; k < n; k++) tick(1'b0, 3'd0, 7'd0, '0, 1'b0, 1'b0, hs);
  endtask

  // Streams the queued words, advancing only on a model-predicted handshake.
  task automatic send(input int stall_pct);
    int   k, guard;
    logic v, hs;
    k = 0; guard = 0;
    while (k < s_b.size()) begin
      v = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      tick(v, 3'(s_b[k]), 7'(s_i[k]), s_d[k], s_l[k], 1'b0, hs);
      if (hs) k++;
      guard++;
      if (guard > 3000) begin
        chk("send_timeout", 32'(guard), 32'(0));
        break;
      end
    end
    s_b.delete(); s_i.delete(); s_d.delete(); s_l.delete();
  endtask

  task automatic push_word(input int b, input int i, input logic [W-1:0] d, input logic l);
    s_b.push_back(b); s_i.push_back(i); s_d.push_back(d); s_l.push_back(l);
  endtask

  typedef struct {
    logic v; logic [2:0] b; logic [6:0] i; logic [W-1:0] d; logic l;
    logic e_ready; logic e_err; logic [6:0] e_wr;
  } vec_t;
  vec_t tbl[15];

  initial begin
    logic hs;
    int   b, dep, len, kind, p, ok;
    m_ready = 1'b0; m_err = 1'b0; m_wr = '0;

    tbl[0]  = '{1, 1, 0, 20'(100),  0, 1, 0, 7'b0000000};
    tbl[1]  = '{1, 1, 1, 20'(-200), 0, 1, 0, 7'b0000000};
    tbl[2]  = '{1, 1, 2, 20'(300),  1, 0, 0, 7'b0000010};
    tbl[3]  = '{0, 0, 0, 20'(0),    0, 1, 0, 7'b0000000};
    tbl[4]  = '{1, 4, 0, 20'(11),   0, 1, 0, 7'b0000000};
    tbl[5]  = '{1, 4, 1, 20'(22),   1, 0, 0, 7'b0010000};
    tbl[6]  = '{0, 0, 0, 20'(0),    0, 1, 0, 7'b0000000};
    tbl[7]  = '{1, 4, 0, 20'(55),   0, 1, 0, 7'b0000000};
    tbl[8]  = '{1, 4, 0, 20'(66),   1, 0, 1, 7'b0000000};
    tbl[9]  = '{0, 0, 0, 20'(0),    0, 1, 0, 7'b0000000};
    tbl[10] = '{1, 7, 0, 20'(1),    0, 1, 0, 7'b0000000};
    tbl[11] = '{1, 7, 1, 20'(2),    0, 1, 0, 7'b0000000};
    tbl[12] = '{1, 7, 2, 20'(3),    0, 1, 0, 7'b0000000};
    tbl[13] = '{1, 7, 3, 20'(4),    1, 0, 1, 7'b0000000};
    tbl[14] = '{0, 0, 0, 20'(0),    0, 1, 0, 7'b0000000};

    for (int k = 0; k < 3; k++) tick(1'b0, 3'd0, 7'd0, '0, 1'b0, 1'b1, hs);
    chk("reset_ready", 32'(cfg_ready), 32'(0));
    idle(1);
    chk("ready_after_reset", 32'(cfg_ready), 32'(1));

    for (int k = 0; k < 15; k++) begin
      tick(tbl[k].v, tbl[k].b, tbl[k].i, tbl[k].d, tbl[k].l, 1'b0, hs);
      chk($sformatf("tbl%0d_ready", k), 32'(cfg_ready), 32'(tbl[k].e_ready));
      chk($sformatf("tbl%0d_err", k), 32'(cfg_error), 32'(tbl[k].e_err));
      chk($sformatf("tbl%0d_wr", k), 32'(dut_wr), 32'(tbl[k].e_wr));
      if (k == 3) chk("num_2_4_array", {n24_out, 4'h0} >> 4 == {20'(300), 20'(-200), 20'(100)}, 1);
      if (k == 9) chk("den_2_held", 32'(d2_out == {20'(22), 20'(11)}), 32'(1));
    end

    // Full frac_dec burst with random stalls.
    frac_pulses = 0;
    for (int k = 0; k < 72; k++) push_word(0, k, 20'(k), k == 71);
    send(30);
    idle(2);
    chk("frac_pulses", 32'(frac_pulses), 32'(1));
    ok = 1;
    for (int k = 0; k < 72; k++) if (frac_out[k*W +: W] !== 20'(k)) ok = 0;
    chk("frac_taps", 32'(ok), 32'(1));

    // Back-to-back bank 2 then bank 5 with valid held high.
    push_word(2, 0, 20'h00aaa, 0); push_word(2, 1, 20'h00bbb, 1);
    push_word(5, 0, 20'h00ccc, 0); push_word(5, 1, 20'h00ddd, 0); push_word(5, 2, 20'h00eee, 1);
    send(0);
    idle(2);
    chk("b2b_gap", 32'(wr5_cyc - wr2_cyc), 32'(4));

    // Reset in the middle of a bank 3 burst.
    tick(1'b1, 3'd3, 7'd0, 20'h1, 1'b0, 1'b0, hs);
    tick(1'b1, 3'd3, 7'd1, 20'h2, 1'b0, 1'b0, hs);
    tick(1'b0, 3'd0, 7'd0, 20'h0, 1'b0, 1'b1, hs);
    chk("rst_ready_low", 32'(cfg_ready), 32'(0));
    chk("rst_arrays_zero", 32'(|{frac_out, n24_out, d24_out, n2_out, d2_out, n1_out, d1_out}), 32'(0));
    idle(1);
    chk("rst_ready_back", 32'(cfg_ready), 32'(1));
    chk("rst_no_pulse", 32'({cfg_error, dut_wr}), 32'(0));
    for (int k = 0; k < 3; k++) push_word(3, k, 20'(k + 7), k == 2);
    send(0);
    idle(1);
    chk("b3_after_rst", 32'(n2_out == {20'(9), 20'(8), 20'(7)}), 32'(1));

    // Random good and corrupted bursts against the model.
    for (int n = 0; n < 40; n++) begin
      b = $urandom_range(7);
      dep = ref_depth(b);
      kind = $urandom_range(4);
      len = (dep == 0) ? $urandom_range(4, 1) : dep;
      if (kind == 2 && dep > 1) len = $urandom_range(dep - 1, 1);
      if (kind == 3) len = dep + $urandom_range(2, 1);
      p = $urandom_range(len - 1);
      for (int k = 0; k < len; k++) begin
        int bb, ii;
        bb = b; ii = k;
        if (kind == 1 && k == p) ii = (k + 1) % 128;
        if (kind == 4 && k == p && k > 0) bb = (b + 1) % 8;
        push_word(bb, ii, W'($urandom), k == len - 1);
      end
      send(20);
      idle($urandom_range(2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
